sll_iter: RTL
=============

SLL_ITER -- requirements
Module: sll_iter

Interface
REQ-001 The block SHALL have parameter N, default 8, giving operand width; legal values are powers of two >= 4; L = log2(N).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin a shift; sampled only in IDLE.
REQ-005 The block SHALL have port A, input, N bits, the operand to be shifted left logically.
REQ-006 The block SHALL have port B, input, N bits, the unsigned shift amount; the full width is significant.
REQ-007 The block SHALL have port C, output, N bits, the registered result A << B with zero fill.
REQ-008 The block SHALL have port ovf, output, 1 bit, asserted when any 1 bit of A was shifted out.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking C/ovf valid.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL capture A into a working register and B into an amount register, clear the stage counter and the sticky-loss flag, and go to SHIFT.
REQ-013 In SHIFT, stage k (k = 0..L-1, one stage per edge) SHALL shift the working register left by 2^k when B[k]=1 (zero fill) and OR the bits pushed out into the sticky-loss flag; when B[k]=0 it SHALL leave both unchanged.
REQ-014 After the edge that applies stage L-1, the block SHALL enter DONE and load C and ovf in that same edge.
REQ-015 If any of B[N-1:L] is 1, the block SHALL load C = 0 and ovf = |A, regardless of the stage results.
REQ-016 Otherwise, the block SHALL load C = the working register and ovf = the sticky-loss flag.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE.
REQ-018 Latency SHALL be L cycles: with start captured at edge 0, done is high between edge L and edge L+1.
REQ-019 C and ovf SHALL hold their values from the DONE load until the next DONE load.
REQ-020 start SHALL be ignored in SHIFT and DONE, and changes on A/B after capture SHALL have no effect.
REQ-021 The earliest new capture SHALL be at edge L+1; back-to-back operations therefore take L+1 cycles each.
REQ-022 For B=0 the block SHALL produce C=A and ovf=0, still with full L-cycle latency.

Reset
REQ-023 While rst_n=0, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, C=0, ovf=0, busy=0, done=0 and clear all internal registers.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-025 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Verification (N=8)
REQ-026 A=0x81, B=1, start pulse -> done 3 cycles after capture, C=0x02, ovf=1, busy high for 4 cycles.
REQ-027 A=0x0F, B=4 -> C=0xF0, ovf=0; then A=0x0F, B=0 -> C=0x0F, ovf=0.
REQ-028 A=0x01, B=9 -> C=0x00, ovf=1; then A=0x00, B=200 -> C=0x00, ovf=0.
REQ-029 Capture A=0x03, B=2; hold start=1 and set A=0xFF during busy -> exactly one done, C=0x0C, next capture at edge 4.
REQ-030 Capture A=0xFF, B=7; pulse rst_n low at edge 1 -> outputs 0 immediately, no done pulse; a new start after release completes normally.

Source files
------------

// File: rtl/sll_iter_if.sv
// Handshake bundle for the iterative logical-left shifter: request side
// (start/A/B) and registered result side (C/ovf/busy/done).
interface sll_iter_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] C;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (output start, A, B, input C, ovf, busy, done);
  modport slave  (input start, A, B, output C, ovf, busy, done);
endinterface

// File: rtl/sll_iter.sv
// Iterative logical-left shifter: one log-shifter stage per clock, tracking
// any 1 bits pushed off the top as an overflow flag.
module sll_iter #(
  parameter int N = 8
) (
  input logic       clk,
  input logic       rst_n,
  sll_iter_if.slave bus
);

  localparam int L  = $clog2(N);
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   work_q, work_d;
  logic [N-1:0]   amt_q, amt_d;
  logic [N-1:0]   c_q, c_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sticky_q, sticky_d;
  logic           aNz_q, aNz_d;
  logic           ovf_q, ovf_d;
  logic           busy_q, done_q;
  logic [2*N-1:0] wideShift;

  // Upper half of wideShift holds whatever this stage pushes out of the word.
  always_comb begin
    wideShift = {{N{1'b0}}, work_q} << (32'd1 << cnt_q);
    state_d   = state_q;
    work_d    = work_q;
    amt_d     = amt_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    aNz_d     = aNz_q;
    c_d       = c_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d   = bus.A;
          amt_d    = bus.B;
          aNz_d    = |bus.A;
          cnt_d    = '0;
          sticky_d = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (amt_q[cnt_q]) begin
          work_d   = wideShift[N-1:0];
          sticky_d = sticky_q | (|wideShift[2*N-1:N]);
        end
        if (cnt_q == CW'(L-1)) begin
          state_d = DONE;
          // Amounts of N or more clear the word and lose every set bit.
          if (|amt_q[N-1:L]) begin
            c_d   = '0;
            ovf_d = aNz_q;
          end else begin
            c_d   = work_d;
            ovf_d = sticky_d;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      amt_q    <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      aNz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      amt_q    <= amt_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      aNz_q    <= aNz_d;
      ovf_q    <= ovf_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  assign bus.C    = c_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
